lock_sequencer: RTL and testbench

LOCK_SEQUENCER -- requirements
Module: lock_sequencer

---
 rtl/lock_sequencer.sv | 131 +++++++++++++
 tb/tb_lock_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_sequencer.sv
// Combination lock sequencer: digit entry, compare, timed unlock,
// failed-attempt lockout with alarm, and in-place code reprogramming.
module lock_sequencer #(
   parameter int NDIG = 4,
   parameter int MAX_TRY = 3,
   parameter int OPEN_CYC = 8,
   parameter int LOCK_CYC = 16,
   parameter logic [4*NDIG-1:0] CODE_RST = 16'h1234
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   output logic       key_ready,
   input  logic       prog,
   output logic       unlock,
   output logic       alarm,
   output logic       done,
   output logic       busy,
   output logic [1:0] tries
);

   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int MC = (OPEN_CYC > LOCK_CYC) ? OPEN_CYC : LOCK_CYC;
   localparam int TW = $clog2(MC) + 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
   localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_CYC - 1);
   localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_CYC - 1);
   localparam logic [1:0] TRY_MAX = 2'(MAX_TRY);

   typedef enum logic [2:0] {
      S_IDLE, S_ENTER, S_CHECK, S_OPEN, S_FAIL, S_LOCK, S_PROG
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [IW-1:0]       r_idx;
   logic [TW-1:0]       r_tmr;
   logic [4*NDIG-1:0]   r_ent;
   logic [4*NDIG-1:0]   r_code;
   logic [4*NDIG-1:0]   w_ent_nx;
   logic [1:0]          r_tries;
   logic [1:0]          w_tries_nx;
   logic                r_done;
   logic                w_rdy;
   logic                w_take;
   logic                w_last;
   logic                w_fin;

   assign w_rdy  = (r_state == S_ENTER) || (r_state == S_PROG);
   assign w_take = key_valid & w_rdy;
   assign w_last = w_take && (r_idx == IDX_LAST);
   assign w_tries_nx = (r_tries == TRY_MAX) ? r_tries : r_tries + 2'd1;

   // Finishing edges: every return to IDLE except the idle self-loop
   assign w_fin = (w_next == S_IDLE) && (r_state != S_IDLE);

   assign key_ready = w_rdy;
   assign unlock    = (r_state == S_OPEN);
   assign alarm     = (r_state == S_LOCK);
   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;
   assign tries     = r_tries;

   always_comb begin
      w_ent_nx = r_ent;
      for (int i = 0; i < NDIG; i++) begin
         if (r_idx == IW'(i)) begin
            w_ent_nx[4*(NDIG-1-i) +: 4] = key_digit;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_next = S_ENTER;
         S_ENTER: if (w_last) w_next = S_CHECK;
         S_CHECK: w_next = (r_ent == r_code) ? S_OPEN : S_FAIL;
         S_OPEN: begin
            if (prog) w_next = S_PROG;
            else if (r_tmr == OPEN_LAST) w_next = S_IDLE;
         end
         S_FAIL:  w_next = (w_tries_nx == TRY_MAX) ? S_LOCK : S_IDLE;
         S_LOCK:  if (r_tmr == LOCK_LAST) w_next = S_IDLE;
         S_PROG:  if (w_last) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx   <= '0;
         r_tmr   <= '0;
         r_ent   <= '0;
         r_code  <= CODE_RST;
         r_tries <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_fin;
         if (r_state == S_IDLE) begin
            r_idx <= '0;
         end else if (w_take) begin
            r_ent <= w_ent_nx;
            r_idx <= w_last ? '0 : r_idx + IW'(1);
         end
         // Timer only runs while dwelling in OPEN or LOCK
         if (((r_state == S_OPEN) || (r_state == S_LOCK)) &&
             (w_next == r_state)) begin
            r_tmr <= r_tmr + TW'(1);
         end else begin
            r_tmr <= '0;
         end
         if ((r_state == S_PROG) && w_last) r_code <= w_ent_nx;
         if ((r_state == S_CHECK) && (w_next == S_OPEN)) begin
            r_tries <= '0;
         end else if (r_state == S_FAIL) begin
            r_tries <= w_tries_nx;
         end else if ((r_state == S_LOCK) && (w_next == S_IDLE)) begin
            r_tries <= '0;
         end
      end
   end

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: vector table, directed corner sequences,
// and random traffic against a transaction-level lock model.
module tb_lock_sequencer;

   localparam int NDIG = 4;
   localparam int MAX_TRY = 3;
   localparam int OPEN_CYC = 8;
   localparam int LOCK_CYC = 16;
   localparam logic [15:0] CODE_RST = 16'h1234;

   localparam int M_IDLE = 0;
   localparam int M_ENTER = 1;
   localparam int M_CHECK = 2;
   localparam int M_OPEN = 3;
   localparam int M_FAIL = 4;
   localparam int M_LOCK = 5;
   localparam int M_PROG = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       key_valid;
   logic [3:0] key_digit;
   logic       key_ready;
   logic       prog;
   logic       unlock;
   logic       alarm;
   logic       done;
   logic       busy;
   logic [1:0] tries;
   logic [6:0] out_vec;

   int errors = 0;
   int checks = 0;

   int   m_mode;
   int   m_fails;
   int   m_n = 0;
   int   m_end;
   logic m_done;
   int   m_q[$];
   int   m_code[NDIG];

   typedef struct {
      logic       s;
      logic       kv;
      logic [3:0] kd;
      logic       p;
      logic [6:0] exp;
   } vec_t;

   vec_t tbl[$];

   lock_sequencer #(
      .NDIG(NDIG), .MAX_TRY(MAX_TRY), .OPEN_CYC(OPEN_CYC),
      .LOCK_CYC(LOCK_CYC), .CODE_RST(CODE_RST)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .key_valid(key_valid), .key_digit(key_digit),
      .key_ready(key_ready), .prog(prog), .unlock(unlock),
      .alarm(alarm), .done(done), .busy(busy), .tries(tries)
   );

   always #5 clk = ~clk;

   assign out_vec = {key_ready, unlock, alarm, done, busy, tries};

   function automatic logic [6:0] exp_vec();
      return {(m_mode == M_ENTER) || (m_mode == M_PROG),
              m_mode == M_OPEN, m_mode == M_LOCK, m_done,
              m_mode != M_IDLE, 2'(m_fails)};
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE;
      m_fails = 0;
      m_done = 1'b0;
      m_q.delete();
      for (int i = 0; i < NDIG; i++)
         m_code[i] = int'((CODE_RST >> (4*(NDIG-1-i))) & 16'hF);
   endtask

   task automatic model_step(input logic s, input logic kv,
                             input logic [3:0] kd, input logic p);
      bit match;
      m_n++;
      m_done = 1'b0;
      case (m_mode)
         M_IDLE: if (s) begin m_mode = M_ENTER; m_q.delete(); end
         M_ENTER: if (kv) begin
            m_q.push_back(int'(kd));
            if (m_q.size() == NDIG) m_mode = M_CHECK;
         end
         M_CHECK: begin
            match = 1'b1;
            for (int i = 0; i < NDIG; i++)
               if (m_q[i] != m_code[i]) match = 1'b0;
            if (match) begin
               m_mode = M_OPEN;
               m_fails = 0;
               m_end = m_n + OPEN_CYC;
            end else m_mode = M_FAIL;
         end
         M_OPEN: begin
            if (p) begin m_mode = M_PROG; m_q.delete(); end
            else if (m_n == m_end) begin m_mode = M_IDLE; m_done = 1'b1; end
         end
         M_FAIL: begin
            m_fails = (m_fails + 1 > MAX_TRY) ? MAX_TRY : m_fails + 1;
            if (m_fails == MAX_TRY) begin
               m_mode = M_LOCK;
               m_end = m_n + LOCK_CYC;
            end else begin
               m_mode = M_IDLE;
               m_done = 1'b1;
            end
         end
         M_LOCK: if (m_n == m_end) begin
            m_mode = M_IDLE;
            m_fails = 0;
            m_done = 1'b1;
         end
         M_PROG: if (kv) begin
            m_q.push_back(int'(kd));
            if (m_q.size() == NDIG) begin
               for (int i = 0; i < NDIG; i++) m_code[i] = m_q[i];
               m_mode = M_IDLE;
               m_done = 1'b1;
            end
         end
         default: m_mode = M_IDLE;
      endcase
   endtask

   task automatic chk(input string nm, input logic [6:0] act,
                      input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%b expected=%b", nm, $time, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, act, exp);
      end
   endtask

   task automatic step(input logic s, input logic kv,
                       input logic [3:0] kd, input logic p);
      start = s;
      key_valid = kv;
      key_digit = kd;
      prog = p;
      @(posedge clk);
      model_step(s, kv, kd, p);
      #1;
      chk("cycle", out_vec, exp_vec());
   endtask

   task automatic arst();
      start = 1'b0;
      key_valid = 1'b0;
      prog = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("arst_async", out_vec, 7'b0);
      @(posedge clk);
      #1;
      chk("arst_hold", out_vec, 7'b0);
      #2;
      rst = 1'b0;
   endtask

   task automatic wait_idle(input bit noise, output int ucnt, output int acnt);
      ucnt = 0;
      acnt = 0;
      for (int k = 0; k < 100 && m_mode != M_IDLE; k++) begin
         step(noise ? 1'($urandom) : 1'b0, noise ? 1'($urandom) : 1'b0,
              4'($urandom), 1'b0);
         ucnt += int'(unlock);
         acnt += int'(alarm);
      end
      if (m_mode != M_IDLE) chk_int("idle_timeout", m_mode, M_IDLE);
   endtask

   task automatic enter(input logic [15:0] c, input bit gaps);
      step(1'b1, 1'b0, 4'h0, 1'b0);
      for (int i = 0; i < NDIG; i++) begin
         if (gaps) repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, 4'($urandom), 1'b0);
         step(1'b0, 1'b1, c[4*(NDIG-1-i) +: 4], 1'b0);
      end
   endtask

   task automatic attempt(input logic [15:0] c, input bit gaps,
                          output int ucnt, output int acnt);
      enter(c, gaps);
      wait_idle(gaps, ucnt, acnt);
   endtask

   task automatic add(input logic s, input logic kv, input logic [3:0] kd,
                      input logic p, input logic [6:0] exp);
      vec_t v;
      v.s = s; v.kv = kv; v.kd = kd; v.p = p; v.exp = exp;
      tbl.push_back(v);
   endtask

   initial begin
      int u, a;
      logic s, kv, p;
      logic [3:0] kd;

      rst = 1'b1;
      start = 1'b0;
      key_valid = 1'b0;
      key_digit = 4'h0;
      prog = 1'b0;
      model_reset();
      #2;
      chk("reset_async", out_vec, 7'b0);
      @(posedge clk);
      #1;
      chk("reset_state", out_vec, 7'b0);
      #2;
      rst = 1'b0;

      // {key_ready, unlock, alarm, done, busy, tries}
      add(1, 0, 4'h0, 0, 7'b1000100);
      add(0, 1, 4'h1, 0, 7'b1000100);
      add(0, 1, 4'h2, 0, 7'b1000100);
      add(0, 1, 4'h3, 0, 7'b1000100);
      add(0, 1, 4'h4, 0, 7'b0000100);
      add(0, 1, 4'h7, 0, 7'b0100100);
      for (int i = 0; i < OPEN_CYC - 1; i++) add(0, 1, 4'h5, 0, 7'b0100100);
      add(0, 0, 4'h0, 0, 7'b0001000);
      add(0, 0, 4'h0, 0, 7'b0000000);
      add(1, 0, 4'h0, 0, 7'b1000100);
      add(0, 1, 4'h1, 0, 7'b1000100);
      add(0, 1, 4'h2, 0, 7'b1000100);
      add(0, 1, 4'h3, 0, 7'b1000100);
      add(0, 1, 4'h5, 0, 7'b0000100);
      add(0, 1, 4'h4, 0, 7'b0000100);
      add(0, 0, 4'h0, 0, 7'b0001001);
      add(0, 0, 4'h0, 0, 7'b0000001);
      foreach (tbl[i]) begin
         step(tbl[i].s, tbl[i].kv, tbl[i].kd, tbl[i].p);
         chk($sformatf("tbl%0d", i), out_vec, tbl[i].exp);
      end

      attempt(16'h1235, 1'b0, u, a);
      chk_int("fail2_tries", int'(tries), 2);
      attempt(16'h1235, 1'b0, u, a);
      chk_int("lock_alarm_cycles", a, LOCK_CYC);
      chk_int("lock_unlock_cycles", u, 0);
      chk_int("lock_exit_tries", int'(tries), 0);

      attempt(16'h1234, 1'b1, u, a);
      chk_int("gap_unlock_cycles", u, OPEN_CYC);
      attempt(16'h1235, 1'b1, u, a);
      chk_int("gap_fail_tries", int'(tries), 1);

      enter(16'h1234, 1'b0);
      step(1'b0, 1'b0, 4'h0, 1'b0);
      step(1'b0, 1'b0, 4'h0, 1'b1);
      step(1'b0, 1'b1, 4'h9, 1'b0);
      step(1'b0, 1'b1, 4'h8, 1'b0);
      step(1'b0, 1'b1, 4'h7, 1'b0);
      step(1'b0, 1'b1, 4'h6, 1'b0);
      chk_int("prog_done", int'(done), 1);
      attempt(16'h1234, 1'b0, u, a);
      chk_int("old_code_unlock", u, 0);
      chk_int("old_code_tries", int'(tries), 1);
      attempt(16'h9876, 1'b0, u, a);
      chk_int("new_code_unlock", u, OPEN_CYC);

      step(1'b1, 1'b0, 4'h0, 1'b0);
      step(1'b0, 1'b1, 4'h9, 1'b0);
      step(1'b0, 1'b1, 4'h8, 1'b0);
      arst();
      attempt(16'h1234, 1'b0, u, a);
      chk_int("revert_unlock", u, OPEN_CYC);

      attempt(16'h1111, 1'b0, u, a);
      attempt(16'h2222, 1'b0, u, a);
      enter(16'hFFFF, 1'b0);
      repeat (3) step(1'b1, 1'b1, 4'hA, 1'b0);
      chk_int("lock_alarm", int'(alarm), 1);
      arst();
      chk_int("lock_rst_tries", int'(tries), 0);
      attempt(16'h1234, 1'b0, u, a);
      chk_int("post_lock_unlock", u, OPEN_CYC);

      attempt(16'h0000, 1'b0, u, a);
      attempt(16'hABCD, 1'b0, u, a);
      chk_int("two_fail_tries", int'(tries), 2);
      attempt(16'h1234, 1'b0, u, a);
      chk_int("recover_tries", int'(tries), 0);
      attempt(16'h4321, 1'b0, u, a);
      attempt(16'h1243, 1'b0, u, a);
      chk_int("no_alarm_yet", a, 0);
      attempt(16'h1230, 1'b0, u, a);
      chk_int("third_alarm", a, LOCK_CYC);

      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 499) == 0) begin
            arst();
         end else begin
            s = ($urandom_range(0, 3) == 0);
            kv = ($urandom_range(0, 2) != 0);
            p = ($urandom_range(0, 9) == 0);
            kd = 4'($urandom);
            if (m_mode == M_ENTER && m_q.size() < NDIG &&
                $urandom_range(0, 4) != 0)
               kd = 4'(m_code[m_q.size()]);
            step(s, kv, kd, p);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
